// File: rtl/clk_div_mon_pkg.sv
// Shared definitions for the divided-clock monitor.
// Holds the FSM state encoding and the default widths and lock threshold
// used by clk_div_monitor.
package clk_div_mon_pkg;

  localparam int DEF_RATIO_WD = 3;
  localparam int DEF_CNT_WD   = DEF_RATIO_WD + 2;
  localparam int DEF_LOCK_CNT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGN   = 2'd1,
    MEASURE = 2'd2
  } state_e;

endpackage

// File: rtl/clk_mon_edge_det.sv
// Sampler and edge detector for the divided clock.
// The divided clock is treated as data: it is registered twice on the
// reference clock and rise/fall pulses are decoded from the two stages.
//   i_clk    reference clock
//   i_rst_n  synchronous active-low reset
//   i_sig    divided clock to sample
//   o_s1     first sample stage
//   o_rise   s1 & ~s2
//   o_fall   ~s1 & s2
module clk_mon_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_s1,
  output logic o_rise,
  output logic o_fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = i_sig;
    s2_d = s1_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign o_s1   = s1_q;
  assign o_rise = s1_q & ~s2_q;
  assign o_fall = ~s1_q & s2_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock ratio monitor.
// Measures the period and high-phase length of i_div_clk in reference
// cycles, compares them against the programmed ratio N and reports lock
// after LOCK_CNT consecutive good periods. Mismatches and missing edges
// raise a sticky error.
//   i_ref_clk     reference clock (only clock)
//   i_rst_n       synchronous active-low reset
//   i_mon_en      monitor enable, 0 forces IDLE
//   i_exp_ratio   expected division ratio N
//   i_div_clk     divided clock, sampled as data
//   i_err_clr     pulse clearing the sticky error
//   o_period      last measured period
//   o_high_cnt    last measured high-phase length
//   o_meas_valid  one-cycle strobe for a new measurement
//   o_lock        ratio confirmed
//   o_ratio_err   sticky mismatch/timeout flag
//   o_bypass      N < 2, nothing to measure
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | disabled or N < 2; no counting
// ALIGN   | waiting for the first rise to start a period
// MEASURE | counting period/high phase, checking on every rise
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int RATIO_WD = DEF_RATIO_WD,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int CNT_WD   = RATIO_WD + 2
) (
  input  logic                i_ref_clk,
  input  logic                i_rst_n,
  input  logic                i_mon_en,
  input  logic [RATIO_WD-1:0] i_exp_ratio,
  input  logic                i_div_clk,
  input  logic                i_err_clr,
  output logic [CNT_WD-1:0]   o_period,
  output logic [CNT_WD-1:0]   o_high_cnt,
  output logic                o_meas_valid,
  output logic                o_lock,
  output logic                o_ratio_err,
  output logic                o_bypass
);

  localparam int GOOD_WD = $clog2(LOCK_CNT + 1);
  localparam logic [GOOD_WD-1:0] LOCK_V = GOOD_WD'(LOCK_CNT);

  logic s1, rise, fall;

  clk_mon_edge_det u_edge_det (
    .i_clk   (i_ref_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_div_clk),
    .o_s1    (s1),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  state_e              state_q, state_d;
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic [CNT_WD-1:0]   hcnt_q, hcnt_d;
  logic                high_done_q, high_done_d;
  logic [CNT_WD-1:0]   period_q, period_d;
  logic [CNT_WD-1:0]   high_q, high_d;
  logic [GOOD_WD-1:0]  good_q, good_d;
  logic [RATIO_WD-1:0] ratio_q, ratio_d;
  logic                meas_valid_q, meas_valid_d;
  logic                lock_q, lock_d;
  logic                err_q, err_d;
  logic                bypass_q, bypass_d;

  logic [CNT_WD-1:0]   n_ext, two_n, cnt_inc, hcnt_inc;
  logic [CNT_WD:0]     h2, n_w, h_diff;
  logic                good_per, timeout, ratio_chg, err_set;

  always_comb begin
    n_ext     = CNT_WD'(i_exp_ratio);
    two_n     = {n_ext[CNT_WD-2:0], 1'b0};
    ratio_d   = i_exp_ratio;
    ratio_chg = (i_exp_ratio != ratio_q);
    bypass_d  = (n_ext < CNT_WD'(2));

    cnt_inc  = (cnt_q == '1)  ? cnt_q  : cnt_q  + CNT_WD'(1);
    hcnt_inc = (hcnt_q == '1) ? hcnt_q : hcnt_q + CNT_WD'(1);

    // Duty check |2*hcnt - N| <= 1, done one bit wider to avoid overflow.
    h2       = {hcnt_q, 1'b0};
    n_w      = {1'b0, n_ext};
    h_diff   = (h2 >= n_w) ? (h2 - n_w) : (n_w - h2);
    good_per = (cnt_q == n_ext) && (h_diff <= (CNT_WD+1)'(1));

    // Fires on the cycle whose increment would bring the count to 2N.
    timeout  = (cnt_q >= (two_n - CNT_WD'(1)));

    state_d      = state_q;
    cnt_d        = cnt_q;
    hcnt_d       = hcnt_q;
    high_done_d  = high_done_q;
    period_d     = period_q;
    high_d       = high_q;
    good_d       = good_q;
    lock_d       = lock_q;
    meas_valid_d = 1'b0;
    err_set      = 1'b0;

    if (!i_mon_en || bypass_d) begin
      state_d = IDLE;
      lock_d  = 1'b0;
      good_d  = '0;
    end else if ((state_q != IDLE) && ratio_chg) begin
      state_d = ALIGN;
      lock_d  = 1'b0;
      good_d  = '0;
    end else begin
      case (state_q)
        IDLE: state_d = ALIGN;
        ALIGN: begin
          if (rise) begin
            state_d     = MEASURE;
            cnt_d       = CNT_WD'(1);
            hcnt_d      = CNT_WD'(1);
            high_done_d = 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d     = cnt_q;
            high_d       = hcnt_q;
            meas_valid_d = 1'b1;
            cnt_d        = CNT_WD'(1);
            hcnt_d       = CNT_WD'(1);
            high_done_d  = 1'b0;
            if (good_per) begin
              good_d = (good_q == LOCK_V) ? good_q : good_q + GOOD_WD'(1);
              lock_d = (good_d == LOCK_V);
            end else begin
              good_d  = '0;
              lock_d  = 1'b0;
              err_set = 1'b1;
            end
          end else if (timeout) begin
            err_set = 1'b1;
            lock_d  = 1'b0;
            good_d  = '0;
            state_d = ALIGN;
          end else begin
            cnt_d = cnt_inc;
            if (fall) begin
              high_done_d = 1'b1;
            end else if (s1 && !high_done_q) begin
              hcnt_d = hcnt_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A new error in the same cycle as a clear keeps the flag set.
    if (err_set) begin
      err_d = 1'b1;
    end else if (i_err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      high_done_q  <= 1'b0;
      period_q     <= '0;
      high_q       <= '0;
      good_q       <= '0;
      ratio_q      <= '0;
      meas_valid_q <= 1'b0;
      lock_q       <= 1'b0;
      err_q        <= 1'b0;
      bypass_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      high_done_q  <= high_done_d;
      period_q     <= period_d;
      high_q       <= high_d;
      good_q       <= good_d;
      ratio_q      <= ratio_d;
      meas_valid_q <= meas_valid_d;
      lock_q       <= lock_d;
      err_q        <= err_d;
      bypass_q     <= bypass_d;
    end
  end

  assign o_period     = period_q;
  assign o_high_cnt   = high_q;
  assign o_meas_valid = meas_valid_q;
  assign o_lock       = lock_q;
  assign o_ratio_err  = err_q;
  assign o_bypass     = bypass_q;

endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 Parameter RATIO_WD, default 3: width of the expected-ratio input.
REQ-002 Parameter LOCK_CNT, default 4: consecutive good periods needed to assert lock.
REQ-003 Parameter CNT_WD, default RATIO_WD+2: width of the period and high-phase counters.
REQ-004 i_ref_clk  input  1  reference clock; the only clock in the block.
REQ-005 i_rst_n  input  1  reset, synchronous and active-low.
REQ-006 i_mon_en  input  1  monitor enable; 0 forces IDLE.
REQ-007 i_exp_ratio  input  RATIO_WD  programmed division ratio N.
REQ-008 i_div_clk  input  1  divided clock, treated as data sampled on i_ref_clk.
REQ-009 i_err_clr  input  1  single-cycle pulse that clears sticky error.
REQ-010 o_period  output  CNT_WD  last measured period, in ref cycles.
REQ-011 o_high_cnt  output  CNT_WD  last measured high-phase length, in ref cycles.
REQ-012 o_meas_valid  output  1  one-cycle strobe marking a new o_period/o_high_cnt.
REQ-013 o_lock  output  1  ratio confirmed.
REQ-014 o_ratio_err  output  1  sticky mismatch or timeout flag.
REQ-015 o_bypass  output  1  N<2, so no measurement is possible.

Function
REQ-016 States SHALL be IDLE, ALIGN and MEASURE.
REQ-017 i_div_clk SHALL be registered into s1, with s2 holding the previous s1; rise = s1 & ~s2 and fall = ~s1 & s2.
REQ-018 IDLE->ALIGN SHALL occur when i_mon_en=1 and N>=2.
REQ-019 ALIGN->MEASURE SHALL occur on rise, loading period counter=1 and high counter=1.
REQ-020 In MEASURE, each non-rise cycle SHALL increment the period counter, and SHALL increment the high counter while s1=1; the high counter freezes after fall.
REQ-021 On rise in MEASURE, the block SHALL load o_period=cnt and o_high_cnt=hcnt, pulse o_meas_valid for 1 cycle, then reload both counters to 1.
REQ-022 A good period SHALL mean cnt==N and |2*hcnt-N|<=1.
REQ-023 On a good period, the good-run counter SHALL increment, saturating at LOCK_CNT; o_lock=1 once the counter reaches LOCK_CNT.
REQ-024 On a bad period, o_lock=0, the good-run counter SHALL clear, and o_ratio_err=1; the state remains MEASURE.
REQ-025 Timeout: if the period counter reaches 2*N with no rise, the block SHALL set o_ratio_err=1 and o_lock=0, clear the good-run counter, and go to ALIGN.
REQ-026 The counters SHALL saturate and never wrap.
REQ-027 If i_exp_ratio changes while not in IDLE (compared against a registered copy), the block SHALL clear o_lock and the good-run counter and go to ALIGN; o_ratio_err is not set.
REQ-028 When N is 0 or 1, o_bypass=1, the state SHALL be IDLE, and o_lock=0.
REQ-029 i_mon_en=0 SHALL force IDLE on the next edge, clearing o_lock, the good-run counter and the strobe; o_period, o_high_cnt and o_ratio_err hold.
REQ-030 o_ratio_err SHALL clear only on i_err_clr or reset.
REQ-031 If i_err_clr coincides with a new error in the same cycle, the error SHALL win and o_ratio_err stays 1.
REQ-032 Measurement latency SHALL be 1 ref cycle from a sampled i_div_clk rise to o_meas_valid.

Reset
REQ-033 On i_rst_n=0 at an i_ref_clk edge, the block SHALL enter IDLE and clear s1/s2, all counters and all outputs; o_bypass reflects the current N after release.
REQ-034 A reset asserted mid-period SHALL discard the partial measurement; no strobe is produced.

Structure
REQ-035 The shared package clk_div_mon_pkg SHALL hold the state enum (IDLE/ALIGN/MEASURE) and the default RATIO_WD, CNT_WD and LOCK_CNT values.
REQ-036 A single sub-module, clk_mon_edge_det, SHALL implement the sample registers and the rise/fall pulse outputs; the FSM, counters and checker stay in the top module.

Verification
REQ-037 N=4, ideal divider (2 high/2 low), enabled -> strobe every 4 cycles with o_period=4, o_high_cnt=2; o_lock=1 on the 4th strobe; o_ratio_err=0.
REQ-038 N=3, divider with 1 high/2 low -> o_period=3, o_high_cnt=1 accepted as good; lock is reached.
REQ-039 Locked at N=4, then one period stretched to 5 -> o_period=5, o_ratio_err=1, o_lock=0; relock after 4 good periods; o_ratio_err stays 1 until an i_err_clr pulse.
REQ-040 N=2, i_div_clk stuck at 0 after ALIGN -> timeout after 4 cycles, o_ratio_err=1, FSM returns to ALIGN.
REQ-041 Locked at N=2, i_exp_ratio changed to 3 -> o_lock=0 next cycle with no error; relock on 3-cycle periods.
REQ-042 N=1 -> o_bypass=1 and no strobes; i_rst_n=0 during MEASURE -> all outputs 0 on the next edge with no strobe.
